// File: rtl/mavg_capture_ctrl.sv
// Capture controller for a moving-average block: drives the averager's factor and clear, then
// packetises its output samples into an AXI-stream FIFO. Define MAVG_CTRL_OVF_COUNT_EN to add ovf_count.
module mavg_capture_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cfg_factor,
  input  logic [15:0]           cfg_pkt_len,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  output logic [31:0]           avg_factor,
  output logic                  avg_clr,
  input  logic                  avg_valid,
  input  logic [DATA_WIDTH-1:0] avg_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  overflow
`ifdef MAVG_CTRL_OVF_COUNT_EN
  ,
  output logic [15:0]           ovf_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state;
  logic [15:0]           pkt_len;
  logic [15:0]           pkt_cnt;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic accepting;
  logic rd_en;
  logic wr_req;
  logic wr_en;
  logic drop;
  logic is_last;

  // A non-zero packet counter in DRAIN means the current packet is still open and must be completed.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accepting  = (state == RUN) || ((state == DRAIN) && (pkt_cnt != 16'd0));
  assign rd_en      = !fifo_empty && m_axis_tready;
  assign wr_req     = accepting && avg_valid;
  assign wr_en      = wr_req && (!fifo_full || rd_en);
  assign drop       = wr_req && fifo_full && !rd_en;
  assign is_last    = (pkt_cnt == (pkt_len - 16'd1));

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? {DATA_WIDTH{1'b0}} : mem_data[rd_ptr[AW-1:0]];
  assign m_axis_tlast  = !fifo_empty && mem_last[rd_ptr[AW-1:0]];

  // FIFO storage; contents are don't-care whenever the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr[AW-1:0]] <= avg_data;
      mem_last[wr_ptr[AW-1:0]] <= is_last;
    end
  end

  // Control FSM, FIFO pointers, packet counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pkt_len    <= 16'd1;
      pkt_cnt    <= 16'd0;
      wr_ptr     <= {(AW+1){1'b0}};
      rd_ptr     <= {(AW+1){1'b0}};
      avg_factor <= 32'd0;
      avg_clr    <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        pkt_cnt <= is_last ? 16'd0 : (pkt_cnt + 16'd1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state      <= CLEAR;
            avg_factor <= cfg_factor;
            pkt_len    <= (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;
            avg_clr    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= RUN;
          avg_clr  <= 1'b0;
          overflow <= 1'b0;
          pkt_cnt  <= 16'd0;
        end
        RUN: begin
          if (cfg_stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && (pkt_cnt == 16'd0)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          avg_clr <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAVG_CTRL_OVF_COUNT_EN
  // Saturating count of dropped samples, restarted with each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= 16'd0;
    end else if (state == CLEAR) begin
      ovf_count <= 16'd0;
    end else if (drop && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mavg_capture_ctrl.sv
// Scoreboard bench for mavg_capture_ctrl: stimulus pushes expected beats, a negedge monitor pops them.
module tb_mavg_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_factor;
  logic [15:0] cfg_pkt_len;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] avg_factor;
  logic        avg_clr;
  logic        avg_valid;
  logic [15:0] avg_data;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        overflow;
`ifdef MAVG_CTRL_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int beats      = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  mavg_capture_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_factor   (cfg_factor),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .avg_factor   (avg_factor),
    .avg_clr      (avg_clr),
    .avg_valid    (avg_valid),
    .avg_data     (avg_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .overflow     (overflow)
`ifdef MAVG_CTRL_OVF_COUNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      beats++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== e) begin
          mismatched++;
          $display("FAIL beat: got last %0b data 0x%0h expected last %0b data 0x%0h",
                   m_axis_tlast, m_axis_tdata, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] factor, input logic [15:0] len);
    cfg_factor  = factor;
    cfg_pkt_len = len;
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic do_stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  // Drive one averager sample; expect_it pushes the hand-computed beat.
  task automatic sample(input logic [15:0] data, input logic last, input logic expect_it);
    avg_valid = 1'b1;
    avg_data  = data;
    if (expect_it) exp_q.push_back({last, data});
    tick();
    avg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_factor = 32'd0; cfg_pkt_len = 16'd0; cfg_start = 1'b0; cfg_stop = 1'b0;
    avg_valid = 1'b0; avg_data = 16'd0; m_axis_tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_factor", avg_factor, 32'd0);
    chk("rst_clr", {31'd0, avg_clr}, 32'd0);
    chk("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);

    // Factor 4, packets of 3, six samples
    do_start(32'd4, 16'd3);
    chk("s1_clr_hi", {31'd0, avg_clr}, 32'd1);
    chk("s1_factor", avg_factor, 32'd4);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("s1_clr_lo", {31'd0, avg_clr}, 32'd0);
    sample(16'h0011, 1'b0, 1'b1);
    sample(16'h0012, 1'b0, 1'b1);
    sample(16'h0013, 1'b1, 1'b1);
    sample(16'h0014, 1'b0, 1'b1);
    sample(16'h0015, 1'b0, 1'b1);
    sample(16'h0016, 1'b1, 1'b1);
    do_stop();
    wait_idle("s1_idle");
    chk("s1_beats", beats, 32'd6);

    // Packet length 0 behaves as 1
    do_start(32'd1, 16'd0);
    tick();
    sample(16'h0021, 1'b1, 1'b1);
    sample(16'h0022, 1'b1, 1'b1);
    sample(16'h0023, 1'b1, 1'b1);
    do_stop();
    wait_idle("s2_idle");
    chk("s2_beats", beats, 32'd9);

    // Back-pressure: four buffered, two dropped
    m_axis_tready = 1'b0;
    do_start(32'd2, 16'd3);
    tick();
    sample(16'h0031, 1'b0, 1'b1);
    sample(16'h0032, 1'b0, 1'b1);
    sample(16'h0033, 1'b1, 1'b1);
    sample(16'h0034, 1'b0, 1'b1);
    sample(16'h0035, 1'b0, 1'b0);
    sample(16'h0036, 1'b0, 1'b0);
    tick(); tick();
    chk("s3_overflow", {31'd0, overflow}, 32'd1);
    chk("s3_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("s3_hold_data", {16'd0, m_axis_tdata}, 32'h0031);
    chk("s3_no_beats", beats, 32'd9);
`ifdef MAVG_CTRL_OVF_COUNT_EN
    chk("s3_ovf_count", {16'd0, ovf_count}, 32'd2);
`endif
    m_axis_tready = 1'b1;
    tick(); tick(); tick(); tick();
    do_stop();
    sample(16'h0037, 1'b0, 1'b1);
    sample(16'h0038, 1'b1, 1'b1);
    wait_idle("s3_idle");
    chk("s3_beats", beats, 32'd15);

    // Stop mid-packet completes the packet, then ignores input
    do_start(32'd3, 16'd3);
    tick();
    chk("s4_overflow_clr", {31'd0, overflow}, 32'd0);
    sample(16'h0041, 1'b0, 1'b1);
    do_stop();
    sample(16'h0042, 1'b0, 1'b1);
    sample(16'h0043, 1'b1, 1'b1);
    sample(16'h0044, 1'b0, 1'b0);
    wait_idle("s4_idle");
    chk("s4_beats", beats, 32'd18);

    // Reset discards buffered samples and wins over start
    m_axis_tready = 1'b0;
    do_start(32'd5, 16'd3);
    tick();
    sample(16'h0051, 1'b0, 1'b0);
    sample(16'h0052, 1'b0, 1'b0);
    chk("s5_tvalid_pre", {31'd0, m_axis_tvalid}, 32'd1);
    rst = 1'b1;
    cfg_start = 1'b1;
    tick();
    rst = 1'b0;
    cfg_start = 1'b0;
    chk("s5_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s5_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("s5_factor", avg_factor, 32'd0);
    m_axis_tready = 1'b1;
    do_start(32'd6, 16'd2);
    tick();
    sample(16'h0053, 1'b0, 1'b1);
    sample(16'h0054, 1'b1, 1'b1);
    do_stop();
    wait_idle("s5_idle");

    // Start during RUN is ignored
    do_start(32'd7, 16'd2);
    tick();
    cfg_factor = 32'd9;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    chk("s6_factor", avg_factor, 32'd7);
    chk("s6_clr", {31'd0, avg_clr}, 32'd0);
    tick();
    chk("s6_clr_next", {31'd0, avg_clr}, 32'd0);
    sample(16'h0061, 1'b0, 1'b1);
    sample(16'h0062, 1'b1, 1'b1);
    do_stop();
    wait_idle("s6_idle");
    tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_beats", beats, 32'd22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
